imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of 32-bit words in the target instruction memory.
REQ-002 SHALL have parameter AW, default 6: word-address width, with 2**AW >= DEPTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that begins a load at word address 0.
REQ-006 SHALL have port byte_valid, input, 1 bit: byte_data is valid this cycle.
REQ-007 SHALL have port byte_data, input, 8 bits: program byte stream, most significant byte of each word first.
REQ-008 SHALL have port byte_last, input, 1 bit: qualified by byte_valid; marks the final byte of the image.
REQ-009 SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-010 SHALL have port mem_we, output, 1 bit: write strobe to the instruction memory write port.
REQ-011 SHALL have port mem_wa, output, AW bits: word address for the write.
REQ-012 SHALL have port mem_wd, output, 32 bits: write data.
REQ-013 SHALL have port busy, output, 1 bit: high in the LOAD and WRITE states.
REQ-014 SHALL have port done, output, 1 bit: high in the DONE state.
REQ-015 SHALL have port word_count, output, AW+1 bits: number of words written since the last start.

Function
REQ-016 SHALL implement the states IDLE, LOAD, WRITE and DONE.
REQ-017 SHALL accept a byte only on a cycle where byte_valid and byte_ready are both high (handshake).
REQ-018 SHALL drive byte_ready high only in LOAD.
REQ-019 SHALL transition IDLE->LOAD on start, clearing the byte index, mem_wa, word_count and the assembly register.
REQ-020 SHALL place accepted bytes, in LOAD, at bits [31:24], [23:16], [15:8] and [7:0] for byte index 0, 1, 2 and 3 respectively.
REQ-021 SHALL transition LOAD->WRITE on acceptance of the byte at index 3, or of any byte with byte_last high.
REQ-022 SHALL zero-fill the unfilled low bytes of a partial word ended by byte_last.
REQ-023 SHALL assert mem_we for exactly one cycle in WRITE, with mem_wd equal to the assembled word and mem_wa equal to the current address.
REQ-024 SHALL give a write latency of one clock: mem_we is high in the cycle after the completing byte handshake.
REQ-025 SHALL, in the cycle following WRITE, increment mem_wa and word_count by 1 and clear the byte index.
REQ-026 SHALL transition WRITE->DONE if the written word carried byte_last or mem_wa equals DEPTH-1, and WRITE->LOAD otherwise.
REQ-027 SHALL wrap mem_wa to 0 after DEPTH-1 is written, while word_count reads DEPTH and the state is DONE.
REQ-028 SHALL never write a word beyond DEPTH-1; bytes offered in DONE are not accepted.
REQ-029 SHALL ignore start in LOAD or WRITE.
REQ-030 SHALL, on start in DONE, clear done and restart exactly as from IDLE.
REQ-031 SHALL hold all state while byte_valid is low in LOAD, with no timeout.
REQ-032 SHALL, if start and byte_valid coincide in IDLE, accept no byte that cycle.
REQ-033 SHALL hold mem_we low in every state other than WRITE, with mem_wd held at the last assembled value.

Reset
REQ-034 SHALL, on reset, go to IDLE and force byte_ready=0, mem_we=0, mem_wa=0, mem_wd=0, busy=0, done=0, word_count=0 and byte index 0.
REQ-035 SHALL give reset priority over start and over all handshakes.
REQ-036 SHALL, on reset asserted mid-load (including during WRITE), suppress mem_we in the following cycle and discard any partial word.

Verification
REQ-037 SHALL verify: start, then bytes 0x8C,0x10,0x00,0x04 back-to-back -> one mem_we at wa=0, wd=0x8C100004, word_count=1, back in LOAD.
REQ-038 SHALL verify: 8 bytes 0x20,0x02,0x00,0x05,0xAC,0x02,0x00,0x54 with byte_last on the 8th -> writes 0x20020005@0 and 0xAC020054@1, done=1, word_count=2.
REQ-039 SHALL verify: 5 bytes 0x11..0x15, byte_last on 0x15 -> writes 0x11121314@0 and 0x15000000@1, then DONE.
REQ-040 SHALL verify: 256 bytes, none with byte_last, DEPTH=64 -> 64 writes at wa 0..63, done=1, word_count=64, mem_wa=0, the 257th byte_valid not accepted.
REQ-041 SHALL verify: reset asserted in the cycle after byte 3's handshake -> no mem_we, all outputs at reset values; a new start then writes from wa=0.
REQ-042 SHALL verify: byte_valid toggled 1/0 every cycle, plus start pulses while busy -> same words as the back-to-back case, and start has no effect while busy.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words and writes them
// sequentially into an instruction memory starting at word address 0.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - synchronous, active-high reset
//   start      - one-cycle pulse; begins a load at word address 0 (from IDLE or DONE)
//   byte_valid - byte_data/byte_last are valid this cycle
//   byte_data  - program byte, most significant byte of each word first
//   byte_last  - final byte of the image (qualified by byte_valid)
//   byte_ready - loader accepts a byte this cycle (LOAD only)
//   mem_we     - one-cycle write strobe (WRITE only)
//   mem_wa     - word write address
//   mem_wd     - write data, holds the last assembled word between writes
//   busy       - high in LOAD and WRITE
//   done       - high in DONE
//   word_count - words written since the last start
module imem_loader #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  input  logic          byte_last,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_wa,
  output logic [31:0]   mem_wd,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   word_count
);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  state_e        state_q;
  logic [1:0]    idx_q;
  logic [31:0]   asm_q;
  logic          we_q;
  logic          last_q;
  logic [AW-1:0] wa_q;
  logic [31:0]   wd_q;
  logic [AW:0]   wc_q;

  logic [31:0]   merged;

  // Byte index 0 lands in [31:24]; shift amount is 8*(3-idx) = {~idx, 3'b000}.
  always_comb begin
    merged = asm_q | ({24'b0, byte_data} << {~idx_q, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      asm_q   <= 32'd0;
      we_q    <= 1'b0;
      last_q  <= 1'b0;
      wa_q    <= '0;
      wd_q    <= 32'd0;
      wc_q    <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StLoad;
            idx_q   <= 2'd0;
            asm_q   <= 32'd0;
            last_q  <= 1'b0;
            wa_q    <= '0;
            wc_q    <= '0;
          end
        end
        StLoad: begin
          if (byte_valid) begin
            if (idx_q == 2'd3 || byte_last) begin
              // Unfilled low bytes are already zero since asm_q is cleared per word.
              wd_q    <= merged;
              we_q    <= 1'b1;
              last_q  <= byte_last;
              state_q <= StWrite;
            end else begin
              asm_q <= merged;
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        StWrite: begin
          asm_q <= 32'd0;
          idx_q <= 2'd0;
          wc_q  <= wc_q + (AW + 1)'(1);
          wa_q  <= (wa_q == LastAddr) ? '0 : wa_q + AW'(1);
          if (last_q || wa_q == LastAddr) begin
            state_q <= StDone;
          end else begin
            state_q <= StLoad;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reset in the WRITE cycle must keep the pending word out of memory.
  assign mem_we     = we_q & ~reset;
  assign mem_wa     = wa_q;
  assign mem_wd     = wd_q;
  assign word_count = wc_q;
  assign byte_ready = (state_q == StLoad);
  assign busy       = (state_q == StLoad) || (state_q == StWrite);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected {wa, wd} writes, a negedge
// monitor pops one entry per mem_we and compares.
module tb_imem_loader;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_last;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [31:0]   mem_wd;
  logic          busy;
  logic          done;
  logic [AW:0]   word_count;

  int checks = 0;
  int errors = 0;

  logic [AW+31:0] exp_q[$];

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_wa     (mem_wa),
    .mem_wd     (mem_wd),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we) begin
      logic [AW+31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got wa=%0d wd=0x%08h expected no write", mem_wa, mem_wd);
      end else begin
        e = exp_q.pop_front();
        if ({mem_wa, mem_wd} !== e) begin
          errors++;
          $display("FAIL write: got wa=%0d wd=0x%08h expected wa=%0d wd=0x%08h",
                   mem_wa, mem_wd, e[AW+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic push_exp(input int wa, input logic [31:0] wd);
    logic [AW-1:0] a;
    a = AW'(wa);
    exp_q.push_back({a, wd});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Offer one byte and hold it until the handshake edge; returns just after that edge.
  task automatic send(input logic [7:0] d, input logic last);
    logic acc;
    int   n;
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = last;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = byte_ready;
      tick();
      n++;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got byte_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_mem_wa"},     32'(mem_wa),     32'd0);
    check({tag, "_mem_wd"},     mem_wd,          32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v2[8];
    logic [7:0] v1[4];
    int acc_cnt;

    v1 = '{8'h8C, 8'h10, 8'h00, 8'h04};
    v2 = '{8'h20, 8'h02, 8'h00, 8'h05, 8'hAC, 8'h02, 8'h00, 8'h54};

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("reset");

    // Single full word, back-to-back bytes; loader returns to LOAD.
    pulse_start();
    push_exp(0, 32'h8C100004);
    for (int i = 0; i < 4; i++) send(v1[i], 1'b0);
    tick();
    @(negedge clk);
    check("t1_word_count", 32'(word_count), 32'd1);
    check("t1_byte_ready", 32'(byte_ready), 32'd1);
    check("t1_mem_wa",     32'(mem_wa),     32'd1);
    check("t1_done",       32'(done),       32'd0);
    tick();
    do_reset();

    // Two words, byte_last on the 8th byte.
    pulse_start();
    push_exp(0, 32'h20020005);
    push_exp(1, 32'hAC020054);
    for (int i = 0; i < 8; i++) send(v2[i], i == 7);
    tick();
    @(negedge clk);
    check("t2_done",       32'(done),       32'd1);
    check("t2_busy",       32'(busy),       32'd0);
    check("t2_word_count", 32'(word_count), 32'd2);

    // Partial final word zero-filled; start from DONE restarts at address 0.
    tick();
    pulse_start();
    @(negedge clk);
    check("t3_restart_done",  32'(done),       32'd0);
    check("t3_restart_count", 32'(word_count), 32'd0);
    tick();
    push_exp(0, 32'h11121314);
    push_exp(1, 32'h15000000);
    for (int i = 0; i < 5; i++) send(8'(8'h11 + i), i == 4);
    tick();
    @(negedge clk);
    check("t3_done",       32'(done),       32'd1);
    check("t3_word_count", 32'(word_count), 32'd2);

    // Fill the whole memory without byte_last.
    tick();
    pulse_start();
    for (int k = 0; k < 64; k++) begin
      push_exp(k, {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)});
    end
    for (int i = 0; i < 256; i++) send(8'(i), 1'b0);
    tick();
    @(negedge clk);
    check("t4_done",       32'(done),       32'd1);
    check("t4_word_count", 32'(word_count), 32'd64);
    check("t4_mem_wa",     32'(mem_wa),     32'd0);
    tick();
    byte_valid = 1'b1;
    byte_data  = 8'hFF;
    acc_cnt    = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (byte_ready) acc_cnt++;
      tick();
    end
    byte_valid = 1'b0;
    check("t4_byte257_accepted", 32'(acc_cnt), 32'd0);
    check("t4_count_after_257",  32'(word_count), 32'd64);

    // Reset during WRITE discards the word; a new load starts at address 0.
    pulse_start();
    for (int i = 0; i < 4; i++) send(8'hEE, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("t5");
    pulse_start();
    push_exp(0, 32'hDEADBEEF);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hEF, 1'b0);
    tick();
    @(negedge clk);
    check("t5_word_count", 32'(word_count), 32'd1);
    tick();
    do_reset();

    // byte_valid toggling with start pulses while busy.
    pulse_start();
    push_exp(0, 32'h8C100004);
    push_exp(1, 32'hAC020054);
    for (int i = 0; i < 8; i++) begin
      send((i < 4) ? v1[i] : v2[i], i == 7);
      if (i != 7) pulse_start();
    end
    tick();
    @(negedge clk);
    check("t6_done",       32'(done),       32'd1);
    check("t6_word_count", 32'(word_count), 32'd2);

    repeat (3) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
